// File: rtl/hash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hash_pkg
// Description : Shared definitions for the SHA-2 control unit. Holds the FSM
//               state encoding, the round counts of the two hash families and
//               the default watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
package hash_pkg;

  // Controller states. The encoding is fixed so that state values are
  // consistent across debug taps and netlists.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_WAIT = 3'd4,
    ST_UPD  = 3'd5,
    ST_DONE = 3'd6
  } hash_state_e;

  // Rounds per block for each family (the datapath owns the round loop).
  localparam int c_rounds_sha256 = 64;
  localparam int c_rounds_sha512 = 80;

  // Default cycles allowed from h_run to kw_done before the watchdog fires.
  localparam int c_wdt_cyc_def = 255;

  // Round count the datapath runs for a given latched mode.
  function automatic int rounds_for(input logic mode384);
    return mode384 ? c_rounds_sha512 : c_rounds_sha256;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hash_cu_wdt.sv
`default_nettype none
// ============================================================================
// Module      : hash_cu_wdt
// Description : Watchdog counter for the SHA-2 control unit. Counts cycles
//               while enabled and flags expiry once WDT_CYC cycles have
//               elapsed since the first enabled cycle.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   clr_i    : synchronous clear (takes priority over en_i)
//   en_i     : count enable
//   expire_o : high while enabled and the limit has been reached
// Revision    : 1.0 - initial release
// ============================================================================
module hash_cu_wdt
  import hash_pkg::*;
#(
  parameter int WDT_CYC = c_wdt_cyc_def
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // The counter only needs to reach WDT_CYC-1: the enabled cycle in which
  // the count equals WDT_CYC-1 is the last one allowed before expiry.
  localparam int c_cnt_w = (WDT_CYC < 2) ? 1 : $clog2(WDT_CYC);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WDT_CYC - 1);

  logic [c_cnt_w-1:0] cnt_q;

  assign expire_o = en_i && (cnt_q == c_last);

  // Holds at the limit so expiry never wraps back to a benign count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hash_cu.sv
`default_nettype none
// ============================================================================
// Module      : hash_cu
// Description : SHA-2 control unit. Sequences the K+W generator and the
//               compression core block by block across a multi-block message:
//               latches the mode, clears/initialises the datapath, admits one
//               block at a time, pulses h_run, waits for kw_done, commits the
//               digest update and presents the final digest.
//               Optional watchdog on the kw_done wait: build macro
//               HASH_CU_WDT_EN (undefined -> no watchdog, err tied 0).
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_start/_mode384   : start pulse and mode (1 = SHA-384/512)
//   cmd_abort            : abort pulse
//   blk_vld/blk_last     : host block available / final block of message
//   blk_rdy              : block accepted (combinational, LOAD state)
//   h_clr/h_run          : datapath clear / block-start pulses
//   h_flg_384            : latched mode to datapath
//   kw_done              : datapath finished all rounds of the block
//   dg_init/dg_upd       : digest IV load / digest accumulate pulses
//   busy                 : controller not idle
//   dig_vld/dig_ack      : final digest handshake
//   blk_cnt              : blocks completed in this message (saturating)
//   err                  : sticky watchdog error
// Revision    : 1.0 - initial release
// ============================================================================
module hash_cu
  import hash_pkg::*;
#(
  parameter int BLK_CNT_W = 8,
  parameter int WDT_CYC   = c_wdt_cyc_def
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_start,
  input  logic                 cmd_mode384,
  input  logic                 cmd_abort,
  input  logic                 blk_vld,
  input  logic                 blk_last,
  output logic                 blk_rdy,
  output logic                 h_clr,
  output logic                 h_run,
  output logic                 h_flg_384,
  input  logic                 kw_done,
  output logic                 dg_init,
  output logic                 dg_upd,
  output logic                 busy,
  output logic                 dig_vld,
  input  logic                 dig_ack,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 err
);

  hash_state_e          state_q;
  logic                 h_clr_q;
  logic                 h_run_q;
  logic                 h_flg_q;
  logic                 dg_init_q;
  logic                 dg_upd_q;
  logic                 busy_q;
  logic                 dig_vld_q;
  logic                 last_q;
  logic [BLK_CNT_W-1:0] blk_cnt_q;
  logic [BLK_CNT_W-1:0] blk_cnt_d;

  // Saturating increment: an all-ones count stays put.
  assign blk_cnt_d = (&blk_cnt_q) ? blk_cnt_q : blk_cnt_q + 1'b1;

`ifdef HASH_CU_WDT_EN
  logic w_wdt_en;
  logic w_wdt_expire;
  logic err_q;

  // The window opens with h_run so that expiry lands exactly WDT_CYC
  // cycles after the h_run pulse.
  assign w_wdt_en = (state_q == ST_RUN) || (state_q == ST_WAIT);

  hash_cu_wdt #(
    .WDT_CYC (WDT_CYC)
  ) u_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!w_wdt_en),
    .en_i     (w_wdt_en),
    .expire_o (w_wdt_expire)
  );

  assign err = err_q;
`else
  // Watchdog absent: the limit parameter has no effect in this build.
  localparam int c_unused_wdt_cyc = WDT_CYC;
  assign err = 1'b0;
`endif

  // Main sequencer. Pulse outputs default low every cycle and are set on
  // the transition into the state that owns them, so each is a one-cycle
  // registered pulse aligned with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_clr_q   <= 1'b0;
      h_run_q   <= 1'b0;
      h_flg_q   <= 1'b0;
      dg_init_q <= 1'b0;
      dg_upd_q  <= 1'b0;
      busy_q    <= 1'b0;
      dig_vld_q <= 1'b0;
      last_q    <= 1'b0;
      blk_cnt_q <= '0;
`ifdef HASH_CU_WDT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      h_clr_q   <= 1'b0;
      h_run_q   <= 1'b0;
      dg_init_q <= 1'b0;
      dg_upd_q  <= 1'b0;

      // Abort outranks every other event; in IDLE it is a no-op so a
      // simultaneous cmd_start still starts the message.
      if (cmd_abort && (state_q != ST_IDLE)) begin
        state_q   <= ST_IDLE;
        h_clr_q   <= 1'b1;
        busy_q    <= 1'b0;
        dig_vld_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_start) begin
              state_q   <= ST_INIT;
              h_flg_q   <= cmd_mode384;
              blk_cnt_q <= '0;
              busy_q    <= 1'b1;
              h_clr_q   <= 1'b1;
              dg_init_q <= 1'b1;
`ifdef HASH_CU_WDT_EN
              err_q     <= 1'b0;
`endif
            end
          end

          ST_INIT: begin
            state_q <= ST_LOAD;
          end

          ST_LOAD: begin
            if (blk_vld) begin
              last_q  <= blk_last;
              state_q <= ST_RUN;
              h_run_q <= 1'b1;
            end
          end

          ST_RUN: begin
            state_q <= ST_WAIT;
          end

          ST_WAIT: begin
            // A kw_done arriving in the final watchdog cycle still counts.
            if (kw_done) begin
              state_q   <= ST_UPD;
              dg_upd_q  <= 1'b1;
              blk_cnt_q <= blk_cnt_d;
            end
`ifdef HASH_CU_WDT_EN
            else if (w_wdt_expire) begin
              state_q <= ST_IDLE;
              err_q   <= 1'b1;
              h_clr_q <= 1'b1;
              busy_q  <= 1'b0;
            end
`endif
          end

          ST_UPD: begin
            if (last_q) begin
              state_q   <= ST_DONE;
              dig_vld_q <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end

          ST_DONE: begin
            if (dig_ack) begin
              state_q   <= ST_IDLE;
              dig_vld_q <= 1'b0;
              busy_q    <= 1'b0;
            end
          end

          default: begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            dig_vld_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign blk_rdy   = (state_q == ST_LOAD);
  assign h_clr     = h_clr_q;
  assign h_run     = h_run_q;
  assign h_flg_384 = h_flg_q;
  assign dg_init   = dg_init_q;
  assign dg_upd    = dg_upd_q;
  assign busy      = busy_q;
  assign dig_vld   = dig_vld_q;
  assign blk_cnt   = blk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_cu.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_cu
// Description : Self-checking bench for hash_cu. Each stimulus action
//               schedules the outputs it must cause (pulses at a cycle,
//               level changes from a cycle on); one compare process checks
//               every output against that schedule on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_cu;

  localparam int BLK_CNT_W = 8;
`ifdef HASH_CU_WDT_EN
  localparam int WDT_CYC = 16;
`else
  localparam int WDT_CYC = 255;
`endif
  localparam int N = 8192;

  // Pulse ids and level ids of the expectation schedule.
  localparam int P_CLR = 0, P_RUN = 1, P_INIT = 2, P_UPD = 3;
  localparam int L_BUSY = 0, L_RDY = 1, L_VLD = 2, L_FLG = 3, L_CNT = 4, L_ERR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_start = 1'b0, cmd_mode384 = 1'b0, cmd_abort = 1'b0;
  logic blk_vld = 1'b0, blk_last = 1'b0, kw_done = 1'b0, dig_ack = 1'b0;
  logic blk_rdy, h_clr, h_run, h_flg_384, dg_init, dg_upd, busy, dig_vld, err;
  logic [BLK_CNT_W-1:0] blk_cnt;

  hash_cu #(.BLK_CNT_W(BLK_CNT_W), .WDT_CYC(WDT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_mode384(cmd_mode384),
    .cmd_abort(cmd_abort), .blk_vld(blk_vld), .blk_last(blk_last), .blk_rdy(blk_rdy),
    .h_clr(h_clr), .h_run(h_run), .h_flg_384(h_flg_384), .kw_done(kw_done),
    .dg_init(dg_init), .dg_upd(dg_upd), .busy(busy), .dig_vld(dig_vld),
    .dig_ack(dig_ack), .blk_cnt(blk_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit pulse_exp [4][N];
  int lvl_chg   [6][N];
  int cur       [6];
  bit chk_en = 0;
  int tests = 0;
  int fails = 0;
  int n_run = 0;
  int n_upd = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void pulse_at(input int k, input int id);
    if (k < N) pulse_exp[id][k] = 1'b1;
  endfunction

  function automatic void lvl_at(input int k, input int id, input int v);
    if (k < N) lvl_chg[id][k] = v;
  endfunction

  // Compare process: every output, every cycle, against the schedule.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) cur[i] = 0;
    end else if (chk_en && cyc < N) begin
      for (int i = 0; i < 6; i++)
        if (lvl_chg[i][cyc] >= 0) cur[i] = lvl_chg[i][cyc];
      if (h_run) n_run++;
      if (dg_upd) n_upd++;
      chk("h_clr",     int'(h_clr),     int'(pulse_exp[P_CLR][cyc]));
      chk("h_run",     int'(h_run),     int'(pulse_exp[P_RUN][cyc]));
      chk("dg_init",   int'(dg_init),   int'(pulse_exp[P_INIT][cyc]));
      chk("dg_upd",    int'(dg_upd),    int'(pulse_exp[P_UPD][cyc]));
      chk("busy",      int'(busy),      cur[L_BUSY]);
      chk("blk_rdy",   int'(blk_rdy),   cur[L_RDY]);
      chk("dig_vld",   int'(dig_vld),   cur[L_VLD]);
      chk("h_flg_384", int'(h_flg_384), cur[L_FLG]);
      chk("blk_cnt",   int'(blk_cnt),   cur[L_CNT]);
      chk("err",       int'(err),       cur[L_ERR]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a message; returns in the first cycle blocks are accepted.
  task automatic do_start(input bit mode, input bit with_abort);
    int c;
    c = cyc;
    cmd_start = 1'b1; cmd_mode384 = mode; cmd_abort = with_abort;
    pulse_at(c + 1, P_CLR); pulse_at(c + 1, P_INIT);
    lvl_at(c + 1, L_BUSY, 1); lvl_at(c + 1, L_FLG, int'(mode));
    lvl_at(c + 1, L_CNT, 0); lvl_at(c + 1, L_ERR, 0);
    lvl_at(c + 2, L_RDY, 1);
    step();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    chk("start_h_clr_t1", int'(h_clr), 1);
    chk("start_dg_init_t1", int'(dg_init), 1);
    chk("start_rdy_t1", int'(blk_rdy), 0);
    step();
    chk("start_rdy_t2", int'(blk_rdy), 1);
  endtask

  // One block from the LOAD state: gap idle cycles, handshake, kw_done lat
  // cycles after h_run; n is the count expected after this block.
  task automatic do_block(input int gap, input bit last, input int lat, input int n,
                          input bit poke, input bit mode);
    int c, w;
    for (int i = 0; i < gap; i++) begin
      kw_done = (i == 5);             // stray kw_done while loading
      step();
    end
    kw_done = 1'b0;
    c = cyc;
    blk_vld = 1'b1; blk_last = last;
    pulse_at(c + 1, P_RUN); lvl_at(c + 1, L_RDY, 0);
    step();
    blk_vld = 1'b0; blk_last = 1'b0;
    chk("blk_h_run", int'(h_run), 1);
    chk("blk_flg", int'(h_flg_384), int'(mode));
    for (int i = 0; i < lat; i++) begin
      cmd_start = poke && (i == 10);
      cmd_mode384 = (poke && (i >= 10)) ? ~mode : mode;
      step();
    end
    cmd_start = 1'b0;
    w = cyc;
    kw_done = 1'b1;
    pulse_at(w + 1, P_UPD); lvl_at(w + 1, L_CNT, n);
    if (last) lvl_at(w + 2, L_VLD, 1);
    else      lvl_at(w + 2, L_RDY, 1);
    step();
    kw_done = 1'b0;
    step();
  endtask

  task automatic do_ack(input int delay);
    int c;
    repeat (delay) step();
    c = cyc;
    dig_ack = 1'b1;
    lvl_at(c + 1, L_VLD, 0); lvl_at(c + 1, L_BUSY, 0);
    step();
    dig_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, u0, c;
    for (int i = 0; i < 4; i++) for (int k = 0; k < N; k++) pulse_exp[i][k] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cur[i] = 0;
      for (int k = 0; k < N; k++) lvl_chg[i][k] = -1;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_h_clr", int'(h_clr), 0);   chk("rst_h_run", int'(h_run), 0);
    chk("rst_busy", int'(busy), 0);     chk("rst_blk_rdy", int'(blk_rdy), 0);
    chk("rst_dig_vld", int'(dig_vld), 0); chk("rst_flg", int'(h_flg_384), 0);
    chk("rst_blk_cnt", int'(blk_cnt), 0); chk("rst_err", int'(err), 0);
    rst_n = 1'b1; chk_en = 1'b1;
    step(); step();

    // SHA-256 single block, digest taken in the first dig_vld cycle.
    r0 = n_run; u0 = n_upd;
    do_start(1'b0, 1'b0);
    do_block(0, 1'b1, 66, 1, 1'b0, 1'b0);
    chk("t1_dig_vld", int'(dig_vld), 1);
    chk("t1_blk_cnt", int'(blk_cnt), 1);
    chk("t1_runs", n_run - r0, 1);
    chk("t1_upds", n_upd - u0, 1);
    do_ack(0);
    chk("t1_idle", int'(busy), 0);
    step(); step();

    // SHA-384 three blocks, start/mode pokes while busy.
    r0 = n_run;
    do_start(1'b1, 1'b0);
    do_block(2, 1'b0, 70, 1, 1'b0, 1'b1);
    do_block(0, 1'b0, 80, 2, 1'b1, 1'b1);
    cmd_mode384 = 1'b0;
    do_block(1, 1'b1, 66, 3, 1'b0, 1'b1);
    chk("t2_blk_cnt", int'(blk_cnt), 3);
    chk("t2_runs", n_run - r0, 3);
    chk("t2_flg", int'(h_flg_384), 1);
    do_ack(3);
    step();

    // Abort in WAIT of block 2, colliding with kw_done.
    u0 = n_upd;
    do_start(1'b0, 1'b0);
    do_block(0, 1'b0, 66, 1, 1'b0, 1'b0);
    c = cyc;
    blk_vld = 1'b1;
    pulse_at(c + 1, P_RUN); lvl_at(c + 1, L_RDY, 0);
    step();
    blk_vld = 1'b0;
    repeat (10) step();
    c = cyc;
    cmd_abort = 1'b1; kw_done = 1'b1;
    pulse_at(c + 1, P_CLR); lvl_at(c + 1, L_BUSY, 0);
    step();
    cmd_abort = 1'b0; kw_done = 1'b0;
    chk("t3_h_clr", int'(h_clr), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_blk_cnt", int'(blk_cnt), 1);
    step();
    chk("t3_upds", n_upd - u0, 1);
    // Abort while idle does nothing.
    cmd_abort = 1'b1; step(); cmd_abort = 1'b0; step();

    // Restart with start+abort together; back-pressure 20 cycles.
    do_start(1'b1, 1'b1);
    do_block(20, 1'b1, 66, 1, 1'b0, 1'b1);
    chk("t4_blk_cnt", int'(blk_cnt), 1);
    do_ack(2);
    step();

    // Block counter saturation.
    do_start(1'b0, 1'b0);
    for (int k = 1; k <= 256; k++)
      do_block(0, k == 256, 1, (k < 255) ? k : 255, 1'b0, 1'b0);
    chk("t5_sat", int'(blk_cnt), 255);
    do_ack(1);
    step();

    // Asynchronous reset mid-message.
    do_start(1'b1, 1'b0);
    do_block(0, 1'b0, 5, 1, 1'b0, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);  chk("arst_rdy", int'(blk_rdy), 0);
    chk("arst_flg", int'(h_flg_384), 0); chk("arst_cnt", int'(blk_cnt), 0);
    step(); step();
    rst_n = 1'b1;
    step(); step();

`ifdef HASH_CU_WDT_EN
    // Watchdog: kw_done never comes.
    do_start(1'b0, 1'b0);
    c = cyc;
    blk_vld = 1'b1; blk_last = 1'b1;
    pulse_at(c + 1, P_RUN); lvl_at(c + 1, L_RDY, 0);
    step();
    blk_vld = 1'b0; blk_last = 1'b0;
    pulse_at(c + 1 + WDT_CYC, P_CLR);
    lvl_at(c + 1 + WDT_CYC, L_ERR, 1); lvl_at(c + 1 + WDT_CYC, L_BUSY, 0);
    repeat (WDT_CYC + 4) step();
    chk("wdt_err", int'(err), 1);
    chk("wdt_busy", int'(busy), 0);
    do_start(1'b0, 1'b0);
    chk("wdt_err_clr", int'(err), 0);
    do_block(0, 1'b1, 66, 1, 1'b0, 1'b0);
    do_ack(0);
    step();
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
